// File: rtl/fpu_issue_ctrl.sv
// Issue/writeback sequencer for the combinational FPU: decodes OP-FP instructions,
// holds operands across the multicycle path, then NaN-boxes or sign-extends the result.
module fpu_issue_ctrl #(
  parameter int BUS_WIDTH = 64,
  parameter int OP_LEN    = 6,
  parameter int LAT_BASIC = 2,
  parameter int LAT_DIV   = 8,
  parameter int LAT_SQRT  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_instr,
  input  logic [BUS_WIDTH-1:0] req_rs1_val,
  input  logic [BUS_WIDTH-1:0] req_rs2_val,
  output logic [BUS_WIDTH-1:0] fpu_in1,
  output logic [BUS_WIDTH-1:0] fpu_in2,
  output logic [OP_LEN-1:0]    fpu_op,
  input  logic [BUS_WIDTH-1:0] fpu_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BUS_WIDTH-1:0] rsp_data,
  output logic [4:0]           rsp_rd,
  output logic                 rsp_to_int,
  output logic                 rsp_illegal
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [OP_LEN-1:0] OP_NONE = '1;

  localparam logic [1:0] LC_BASIC = 2'd0;
  localparam logic [1:0] LC_DIV   = 2'd1;
  localparam logic [1:0] LC_SQRT  = 2'd2;

  localparam logic [1:0] PP_PASS = 2'd0;
  localparam logic [1:0] PP_BOX  = 2'd1;
  localparam logic [1:0] PP_SEXT = 2'd2;

  localparam int LAT_MAX = (LAT_BASIC > LAT_DIV) ?
                           ((LAT_BASIC > LAT_SQRT) ? LAT_BASIC : LAT_SQRT) :
                           ((LAT_DIV > LAT_SQRT) ? LAT_DIV : LAT_SQRT);
  localparam int CW = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  typedef struct packed {
    logic              legal;
    logic [OP_LEN-1:0] op;
    logic [1:0]        lc;
    logic              to_int;
    logic [1:0]        pp;
  } dec_t;

  function automatic dec_t mk(input logic [OP_LEN-1:0] op, input logic [1:0] lc,
                              input logic to_int, input logic [1:0] pp);
    dec_t d;
    d.legal  = 1'b1;
    d.op     = op;
    d.lc     = lc;
    d.to_int = to_int;
    d.pp     = pp;
    return d;
  endfunction

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    pp_r;
  dec_t          dec;
  logic [CW-1:0] lat_init;
  logic [BUS_WIDTH-1:0] pp_res;

  logic [6:0] f7, opc;
  logic [4:0] rs2;
  logic [2:0] f3;
  assign f7  = req_instr[31:25];
  assign rs2 = req_instr[24:20];
  assign f3  = req_instr[14:12];
  assign opc = req_instr[6:0];

  // rs1 index is resolved upstream; only the operand value reaches us
  logic unused_rs1;
  assign unused_rs1 = ^req_instr[19:15];

  always_comb begin
    dec       = '0;
    dec.op    = OP_NONE;
    if (opc == 7'b1010011) begin
      case (f7)
        7'b0000001: dec = mk(6'b000000, LC_BASIC, 1'b0, PP_PASS);
        7'b0000000: dec = mk(6'b000001, LC_BASIC, 1'b0, PP_BOX);
        7'b0000101: dec = mk(6'b000010, LC_BASIC, 1'b0, PP_PASS);
        7'b0000100: dec = mk(6'b000011, LC_BASIC, 1'b0, PP_BOX);
        7'b0001001: dec = mk(6'b000100, LC_BASIC, 1'b0, PP_PASS);
        7'b0001000: dec = mk(6'b000101, LC_BASIC, 1'b0, PP_BOX);
        7'b0001101: dec = mk(6'b000110, LC_DIV,   1'b0, PP_PASS);
        7'b0001100: dec = mk(6'b000111, LC_DIV,   1'b0, PP_BOX);
        7'b0101101: if (rs2 == 5'd0) dec = mk(6'b001000, LC_SQRT, 1'b0, PP_PASS);
        7'b0101100: if (rs2 == 5'd0) dec = mk(6'b001001, LC_SQRT, 1'b0, PP_BOX);
        7'b0010001: case (f3)
          3'b000:  dec = mk(6'b011010, LC_BASIC, 1'b0, PP_PASS);
          3'b001:  dec = mk(6'b011100, LC_BASIC, 1'b0, PP_PASS);
          3'b010:  dec = mk(6'b011110, LC_BASIC, 1'b0, PP_PASS);
          default: ;
        endcase
        7'b0010000: case (f3)
          3'b000:  dec = mk(6'b011011, LC_BASIC, 1'b0, PP_BOX);
          3'b001:  dec = mk(6'b011101, LC_BASIC, 1'b0, PP_BOX);
          3'b010:  dec = mk(6'b011111, LC_BASIC, 1'b0, PP_BOX);
          default: ;
        endcase
        7'b0010101: case (f3)
          3'b000:  dec = mk(6'b010000, LC_BASIC, 1'b0, PP_PASS);
          3'b001:  dec = mk(6'b010010, LC_BASIC, 1'b0, PP_PASS);
          default: ;
        endcase
        7'b0010100: case (f3)
          3'b000:  dec = mk(6'b010001, LC_BASIC, 1'b0, PP_BOX);
          3'b001:  dec = mk(6'b010011, LC_BASIC, 1'b0, PP_BOX);
          default: ;
        endcase
        7'b1010001: case (f3)
          3'b010:  dec = mk(6'b010100, LC_BASIC, 1'b1, PP_PASS);
          3'b001:  dec = mk(6'b010110, LC_BASIC, 1'b1, PP_PASS);
          3'b000:  dec = mk(6'b011000, LC_BASIC, 1'b1, PP_PASS);
          default: ;
        endcase
        // single compares land in the int regfile, so widen with sign, not NaN-box
        7'b1010000: case (f3)
          3'b010:  dec = mk(6'b010101, LC_BASIC, 1'b1, PP_SEXT);
          3'b001:  dec = mk(6'b010111, LC_BASIC, 1'b1, PP_SEXT);
          3'b000:  dec = mk(6'b011001, LC_BASIC, 1'b1, PP_SEXT);
          default: ;
        endcase
        7'b1110001: if (f3 == 3'b000)  dec = mk(6'b100000, LC_BASIC, 1'b1, PP_PASS);
        7'b1111001:                    dec = mk(6'b100001, LC_BASIC, 1'b0, PP_PASS);
        7'b1100001: if (rs2 == 5'd2)   dec = mk(6'b100010, LC_BASIC, 1'b1, PP_PASS);
        7'b1101001: if (rs2 == 5'd2)   dec = mk(6'b100011, LC_BASIC, 1'b0, PP_PASS);
        7'b0100000: if (rs2 == 5'd1)   dec = mk(6'b100100, LC_BASIC, 1'b0, PP_BOX);
        7'b0100001: if (rs2 == 5'd0)   dec = mk(6'b100101, LC_BASIC, 1'b0, PP_PASS);
        7'b1100000: if (rs2 == 5'd0)   dec = mk(6'b100110, LC_BASIC, 1'b1, PP_SEXT);
        7'b1101000: if (rs2 == 5'd0)   dec = mk(6'b100111, LC_BASIC, 1'b0, PP_BOX);
        default: ;
      endcase
    end
  end

  always_comb begin
    case (dec.lc)
      LC_DIV:  lat_init = CW'(LAT_DIV - 1);
      LC_SQRT: lat_init = CW'(LAT_SQRT - 1);
      default: lat_init = CW'(LAT_BASIC - 1);
    endcase
  end

  always_comb begin
    case (pp_r)
      PP_BOX:  pp_res = {{(BUS_WIDTH-32){1'b1}}, fpu_out[31:0]};
      PP_SEXT: pp_res = {{(BUS_WIDTH-32){fpu_out[31]}}, fpu_out[31:0]};
      default: pp_res = fpu_out;
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pp_r        <= PP_PASS;
      fpu_in1     <= '0;
      fpu_in2     <= '0;
      fpu_op      <= OP_NONE;
      rsp_data    <= '0;
      rsp_rd      <= '0;
      rsp_to_int  <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          rsp_rd <= req_instr[11:7];
          if (dec.legal) begin
            fpu_in1    <= req_rs1_val;
            fpu_in2    <= req_rs2_val;
            fpu_op     <= dec.op;
            cnt        <= lat_init;
            pp_r       <= dec.pp;
            rsp_to_int <= dec.to_int;
            state      <= S_EXEC;
          end else begin
            rsp_illegal <= 1'b1;
            rsp_data    <= '0;
            rsp_to_int  <= 1'b0;
            state       <= S_DONE;
          end
        end
        S_EXEC: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            rsp_data <= pp_res;
            state    <= S_DONE;
          end
        end
        S_DONE: if (rsp_ready) begin
          rsp_illegal <= 1'b0;
          fpu_op      <= OP_NONE;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: driver queues expected responses, a negedge
// monitor checks latency, held operands and response fields against the queue head.
module tb_fpu_issue_ctrl;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [31:0] req_instr;
  logic [63:0] req_rs1_val, req_rs2_val;
  logic [63:0] fpu_in1, fpu_in2, fpu_out;
  logic [5:0]  fpu_op;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_to_int, rsp_illegal;

  fpu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
    .req_rs1_val(req_rs1_val), .req_rs2_val(req_rs2_val),
    .fpu_in1(fpu_in1), .fpu_in2(fpu_in2), .fpu_op(fpu_op), .fpu_out(fpu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_to_int(rsp_to_int), .rsp_illegal(rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in FPU: upper halves of single results are junk so boxing/sext is visible
  function automatic logic [63:0] fpu_model(input logic [5:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    case (op)
      6'b000000: return $realtobits($bitstoreal(a) + $bitstoreal(b));
      6'b000110: return $realtobits($bitstoreal(a) / $bitstoreal(b));
      6'b010110: return {63'd0, ($bitstoreal(a) < $bitstoreal(b))};
      6'b011010: return {b[63], a[62:0]};
      6'b100000: return a;
      6'b000001: return (a[31:0] == 32'h3F800000 && b[31:0] == 32'h40000000) ?
                        64'h12345678_40400000 : 64'hBAD0BAD0BAD0BAD0;
      6'b100110: return (a[31:0] == 32'hBF800000) ? 64'h00000000_FFFFFFFF
                                                   : 64'hBAD0BAD0BAD0BAD0;
      6'b111111: return 64'h7FF8000000000000;
      default:   return 64'hBAD0BAD0BAD0BAD0;
    endcase
  endfunction

  always_comb fpu_out = fpu_model(fpu_op, fpu_in1, fpu_in2);

  typedef struct {
    logic [63:0] a, b, data;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic        to_int, illegal;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];
  bit   seen = 0;

  always @(negedge clk) begin
    if (!rst && q.size() > 0) begin
      if (rsp_valid) begin
        if (!seen) begin
          chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
          seen = 1;
        end
        chk("rsp_data", rsp_data, q[0].data);
        chk("rsp_rd", 64'(rsp_rd), 64'(q[0].rd));
        chk("rsp_to_int", 64'(rsp_to_int), 64'(q[0].to_int));
        chk("rsp_illegal", 64'(rsp_illegal), 64'(q[0].illegal));
        chk("done_fpu_op", 64'(fpu_op), 64'(q[0].op));
        chk("done_req_ready", 64'(req_ready), 64'd0);
        if (rsp_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end else if (!req_ready) begin
        chk("exec_fpu_op", 64'(fpu_op), 64'(q[0].op));
        chk("exec_fpu_in1", fpu_in1, q[0].a);
        chk("exec_fpu_in2", fpu_in2, q[0].b);
      end
    end else if (!rst && rsp_valid) begin
      chk("unexpected_rsp_valid", 64'(rsp_valid), 64'd0);
    end
  end

  function automatic logic [31:0] ins(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, 5'd1, f3, rd, 7'b1010011};
  endfunction

  task automatic send(input logic [31:0] instr, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] data, input logic [5:0] op, input logic to_int,
                      input logic illegal, input int lat);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'd1);
    req_valid   = 1'b1;
    req_instr   = instr;
    req_rs1_val = a;
    req_rs2_val = b;
    e.a = a; e.b = b; e.data = data; e.op = op; e.rd = instr[11:7];
    e.to_int = to_int; e.illegal = illegal; e.lat = lat; e.acc = cyc;
    q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() > 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      chk("rsp_timeout", 64'(q.size()), 64'd0);
      q.delete();
      seen = 0;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_instr = '0;
    req_rs1_val = '0; req_rs2_val = '0; rsp_ready = 1'b1;
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_fpu_op", 64'(fpu_op), 64'h3F);
    chk("rst_fpu_in1", fpu_in1, 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_rsp_illegal", 64'(rsp_illegal), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    send(32'h022082D3, 64'h3FF0000000000000, 64'h4000000000000000,
         64'h4008000000000000, 6'b000000, 1'b0, 1'b0, 3);
    wait_done();
    send(ins(7'b0000000, 5'd2, 3'b000, 5'd6), 64'hFFFFFFFF3F800000, 64'hFFFFFFFF40000000,
         64'hFFFFFFFF40400000, 6'b000001, 1'b0, 1'b0, 3);
    wait_done();
    send(ins(7'b1010001, 5'd2, 3'b001, 5'd10), 64'h3FF0000000000000, 64'h4000000000000000,
         64'h0000000000000001, 6'b010110, 1'b1, 1'b0, 3);
    wait_done();
    send(ins(7'b1100000, 5'd0, 3'b111, 5'd11), 64'hFFFFFFFFBF800000, 64'd0,
         64'hFFFFFFFFFFFFFFFF, 6'b100110, 1'b1, 1'b0, 3);
    wait_done();
    send(ins(7'b0010001, 5'd2, 3'b000, 5'd12), 64'h3FF0000000000000, 64'h8000000000000000,
         64'hBFF0000000000000, 6'b011010, 1'b0, 1'b0, 3);
    wait_done();

    // FDIV with writeback stalled for 3 cycles after rsp_valid rises
    rsp_ready = 1'b0;
    send(ins(7'b0001101, 5'd2, 3'b000, 5'd13), 64'h4018000000000000, 64'h4000000000000000,
         64'h4008000000000000, 6'b000110, 1'b0, 1'b0, 9);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_done();

    send(ins(7'b1111111, 5'd2, 3'b000, 5'd14), 64'h1, 64'h2, 64'd0, 6'b111111, 1'b0, 1'b1, 1);
    wait_done();
    send(ins(7'b0010001, 5'd2, 3'b011, 5'd15), 64'h1, 64'h2, 64'd0, 6'b111111, 1'b0, 1'b1, 1);
    wait_done();
    send(ins(7'b0101101, 5'd1, 3'b000, 5'd16), 64'h1, 64'h2, 64'd0, 6'b111111, 1'b0, 1'b1, 1);
    wait_done();
    send({7'b0000001, 5'd2, 5'd1, 3'b000, 5'd17, 7'b0110011}, 64'h1, 64'h2, 64'd0,
         6'b111111, 1'b0, 1'b1, 1);
    wait_done();

    // reset lands in the first EXEC cycle of an FADD; the op must vanish at once
    @(negedge clk);
    req_valid = 1'b1; req_instr = 32'h022082D3;
    req_rs1_val = 64'h3FF0000000000000; req_rs2_val = 64'h4000000000000000;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_fpu_op", 64'(fpu_op), 64'h3F);
    chk("midrst_fpu_in1", fpu_in1, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    send(ins(7'b1110001, 5'd0, 3'b000, 5'd7), 64'h0123456789ABCDEF, 64'd0,
         64'h0123456789ABCDEF, 6'b100000, 1'b1, 1'b0, 3);
    wait_done();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Multi-cycle issue/writeback controller that drives the combinational FPU datapath.
- Accepts RV64FD OP-FP instructions with operand values over a valid/ready request port, then decodes funct7/funct3/rs2 into the 6-bit fpu_op encoding.
- Holds the FPU inputs stable for a per-class latency (multicycle path), captures the result, and post-processes it (NaN-boxing, sign-extension).
- Returns the result over a valid/ready response port to the register-file writeback stage.

Parameters:
- BUS_WIDTH, 64, datapath width; only 64 is supported.
- OP_LEN, 6, fpu_op width.
- LAT_BASIC, 2, EXEC cycles for add/sub/mul/min/max/cmp/sgnj/mv/cvt; must be ≥1.
- LAT_DIV, 8, EXEC cycles for fdiv; must be ≥1.
- LAT_SQRT, 8, EXEC cycles for fsqrt; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_instr  in  32  OP-FP instruction word.
- req_rs1_val  in  64  rs1 operand, from the FP or int regfile per the instruction.
- req_rs2_val  in  64  rs2 operand.
- fpu_in1  out  64  FPU operand 1, registered.
- fpu_in2  out  64  FPU operand 2, registered.
- fpu_op  out  6  FPU operation select, registered.
- fpu_out  in  64  FPU combinational result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  writeback accepts the response.
- rsp_data  out  64  final result.
- rsp_rd  out  5  destination register index.
- rsp_to_int  out  1  1 = write the integer regfile, 0 = write the FP regfile.
- rsp_illegal  out  1  decode failed; rsp_data=0.

Behaviour:
- Reset is asynchronous and active-high, on rst. Reset state is IDLE with req_ready=1, rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_to_int=0, rsp_illegal=0, fpu_in1=fpu_in2=0, fpu_op=6'b111111 (unused code; FPU returns canonical NaN).
- FSM states are IDLE, EXEC, DONE. req_ready=1 only in IDLE. rsp_valid=1 only in DONE.
- IDLE:
  - On req_valid, latch the request; rsp_rd=instr[11:7].
  - If the instruction decodes legally: fpu_in1/in2/op are registered, cnt=LAT-1, next state EXEC.
  - If illegal (opcode≠1010011 or no match below): rsp_illegal=1, rsp_data=0, next state DONE.
- EXEC:
  - fpu_in1/in2/op are held constant.
  - When cnt≠0, cnt decrements.
  - When cnt=0, capture the post-processed fpu_out into rsp_data, then go to DONE.
  - Accept→rsp_valid is LAT+1 cycles (illegal: 1 cycle).
- DONE:
  - Hold all rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready, go to IDLE, clear rsp_illegal, set fpu_op=6'b111111.
  - A new request cannot be accepted in the same cycle as the response handshake.
- Decode, written as funct7 → fpu_op (double, single):
  - FADD 0000001/0000000 → 000000/000001.
  - FSUB 0000101/0000100 → 000010/000011.
  - FMUL 0001001/0001000 → 000100/000101.
  - FDIV 0001101/0001100 → 000110/000111, uses LAT_DIV.
  - FSQRT 0101101/0101100, rs2=0 → 001000/001001, uses LAT_SQRT.
  - FSGNJ 0010001/0010000, funct3 000/001/010 → J 011010/011011, JN 011100/011101, JX 011110/011111; other funct3 illegal.
  - FMIN/FMAX 0010101/0010100, funct3 000/001 → 010000/010001, 010010/010011.
  - FEQ/FLT/FLE 1010001/1010000, funct3 010/001/000 → 010100/010101, 010110/010111, 011000/011001; rsp_to_int=1.
  - FMV.X.D 1110001 f3=000 → 100000, to_int=1.
  - FMV.D.X 1111001 → 100001.
  - FCVT.L.D 1100001 rs2=00010 → 100010, to_int=1.
  - FCVT.D.L 1101001 rs2=00010 → 100011.
  - FCVT.S.D 0100000 rs2=00001 → 100100.
  - FCVT.D.S 0100001 rs2=00000 → 100101.
  - FCVT.W.S 1100000 rs2=00000 → 100110, to_int=1.
  - FCVT.S.W 1101000 rs2=00000 → 100111.
  - The rm field is ignored except where it is used as a funct3 selector above.
- Post-processing:
  - Single-precision result to the FP regfile: rsp_data={32'hFFFFFFFF, fpu_out[31:0]} (NaN-box).
  - FCVT.W.S and single compares: sign-extend bit 31.
  - All other results pass through unchanged.
- If rst asserts mid-EXEC or mid-DONE, the in-flight op is dropped and all outputs return to reset values immediately.

Test Plan:
- FADD.D instr 0x022082D3, rs1=3FF0000000000000, rs2=4000000000000000 → rsp_valid exactly 3 cycles after accept; rsp_data=4008000000000000, rsp_rd=5, rsp_to_int=0.
- FADD.S (funct7 0000000), rs1=3F800000, rs2=40000000 → rsp_data=FFFFFFFF40400000.
- FLT.D (funct7 1010001 f3=001), 1.0 vs 2.0 → rsp_data=1, rsp_to_int=1. FCVT.W.S of BF800000 → rsp_data=FFFFFFFFFFFFFFFF.
- FDIV.D 6.0/2.0 → fpu_op=000110 stable for 8 cycles; rsp_data=4008000000000000 at cycle 9. Hold rsp_ready=0 for 3 cycles → rsp_* stable, req_ready=0 throughout.
- funct7=1111111 → rsp_valid the next cycle, rsp_illegal=1, rsp_data=0, fpu_op stays 111111. FSGNJ with f3=011 → illegal.
- Assert rst in EXEC cycle 1 → rsp_valid=0, req_ready=1, fpu_op=111111 before the next edge. A following FMV.X.D of 0123456789ABCDEF returns the same value.
